modmul_rr_arbiter: RTL

- Shares one fully pipelined 32-bit modular multiplier (modulus P = 0xEC940E71, start/done pulse interface, fixed latency, no backpressure) among N_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle.
- Each issued operation is tagged with its requester ID in a latency-matched tag pipe. The result is returned to the originating requester.
- Sits between the sampling/MPC compute engines and the shared multiplier instance.

---
 rtl/modmul_rr_arbiter_pkg.sv | 19 +
 rtl/modmul_rr_arbiter_rr_arb_core.sv | 57 +++++
 rtl/modmul_rr_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/modmul_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// modmul_rr_arbiter_pkg
// Shared constants and types for the modular-multiplier round-robin arbiter.
//   MODMUL_P         : modulus of the attached multiplier
//   MUL_LATENCY_DEF  : default start-to-done latency of the multiplier
//   tag_t            : tag-pipe entry {valid, id}; id sized for up to 8 requesters
// -----------------------------------------------------------------------------
package modmul_rr_arbiter_pkg;

    localparam logic [31:0] MODMUL_P        = 32'hEC940E71;
    localparam int unsigned MUL_LATENCY_DEF = 16;
    localparam int unsigned TAG_ID_W        = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/modmul_rr_arbiter_rr_arb_core.sv
// -----------------------------------------------------------------------------
// modmul_rr_arbiter_rr_arb_core
// Round-robin priority select with its pointer register. The search starts at
// the pointer and wraps; the pointer moves past the winner on every grant.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset (forces grant low)
//   i_req          : per-requester request levels
//   o_gnt          : one-hot grant (combinational)
//   o_gnt_valid    : any grant this cycle
//   o_gnt_id       : index of the granted requester
// -----------------------------------------------------------------------------
module modmul_rr_arbiter_rr_arb_core #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_gnt_valid,
    output logic [ID_W-1:0]  o_gnt_id
);

    logic [ID_W-1:0] r_ptr;
    logic [31:0]     w_idx;

    always_comb begin
        o_gnt       = '0;
        o_gnt_valid = 1'b0;
        o_gnt_id    = '0;
        w_idx       = '0;
        if (!i_rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                w_idx = 32'(r_ptr) + i;
                if (w_idx >= N_REQ) begin
                    w_idx = w_idx - N_REQ;
                end
                if (!o_gnt_valid && i_req[ID_W'(w_idx)]) begin
                    o_gnt_valid = 1'b1;
                    o_gnt_id    = ID_W'(w_idx);
                end
            end
            if (o_gnt_valid) begin
                o_gnt[o_gnt_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (o_gnt_valid) begin
            r_ptr <= (o_gnt_id == ID_W'(N_REQ - 1)) ? '0 : o_gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/modmul_rr_arbiter.sv
// -----------------------------------------------------------------------------
// modmul_rr_arbiter
// Shares one pipelined modular multiplier among N_REQ requesters. A round-robin
// grant feeds a registered issue stage; a latency-matched tag pipe routes each
// multiplier result back to the requester that issued it.
// Ports:
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_req, i_x, i_y      : per-requester request level and packed operands
//   o_gnt                : one-hot grant (combinational)
//   o_mul_start/x/y      : issue to the multiplier
//   i_mul_o, i_mul_done  : multiplier result and done pulse
//   o_res, o_res_valid   : shared result bus and one-hot one-cycle strobe
//   o_err                : sticky tag/done mismatch flag
// Optional (macro MODMUL_ARB_PERF_EN):
//   o_gnt_cnt, o_busy_cnt, o_stall_cnt : saturating 16-bit performance counters
// -----------------------------------------------------------------------------
module modmul_rr_arbiter
    import modmul_rr_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ID_W        = $clog2(N_REQ),
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [32*N_REQ-1:0]   i_x,
    input  logic [32*N_REQ-1:0]   i_y,
    output logic [N_REQ-1:0]      o_gnt,
    output logic                  o_mul_start,
    output logic [31:0]           o_mul_x,
    output logic [31:0]           o_mul_y,
    input  logic [31:0]           i_mul_o,
    input  logic                  i_mul_done,
    output logic [31:0]           o_res,
    output logic [N_REQ-1:0]      o_res_valid,
    output logic                  o_err
`ifdef MODMUL_ARB_PERF_EN
    ,
    output logic [16*N_REQ-1:0]   o_gnt_cnt,
    output logic [15:0]           o_busy_cnt,
    output logic [15:0]           o_stall_cnt
`endif
);

    localparam int unsigned FLUSH_W = $clog2(MUL_LATENCY + 1);

    logic [N_REQ-1:0] w_gnt;
    logic             w_gnt_valid;
    logic [ID_W-1:0]  w_gnt_id;
    logic [31:0]      w_sel_x;
    logic [31:0]      w_sel_y;
    tag_t             w_head;
    logic             w_flushing;

    logic             r_mul_start;
    logic [31:0]      r_mul_x;
    logic [31:0]      r_mul_y;
    logic [ID_W-1:0]  r_issue_id;
    tag_t             r_tag [MUL_LATENCY];
    logic [FLUSH_W-1:0] r_flush;
    logic [31:0]      r_res;
    logic [N_REQ-1:0] r_res_valid;
    logic             r_err;

    modmul_rr_arbiter_rr_arb_core #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .o_gnt       (w_gnt),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    assign o_gnt = w_gnt;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (w_gnt[k]) begin
                w_sel_x = i_x[k*32 +: 32];
                w_sel_y = i_y[k*32 +: 32];
            end
        end
    end

    // Issue stage: operands hold their last value when nothing is granted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mul_start <= 1'b0;
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_issue_id  <= '0;
        end else begin
            r_mul_start <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_mul_x    <= w_sel_x;
                r_mul_y    <= w_sel_y;
                r_issue_id <= w_gnt_id;
            end
        end
    end

    // Tag pipe: entry 0 captures the issue, head lines up with i_mul_done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(MUL_LATENCY); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: r_mul_start, id: TAG_ID_W'(r_issue_id)};
            for (int i = 1; i < int'(MUL_LATENCY); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_head = r_tag[MUL_LATENCY-1];

    // The multiplier is not reset, so stale done pulses may still emerge for
    // MUL_LATENCY cycles after reset; they are ignored while this counts down.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flush <= FLUSH_W'(MUL_LATENCY);
        end else if (r_flush != '0) begin
            r_flush <= r_flush - 1'b1;
        end
    end

    assign w_flushing = (r_flush != '0);

    // Return stage and sticky mismatch flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res       <= '0;
            r_res_valid <= '0;
            r_err       <= 1'b0;
        end else begin
            r_res_valid <= '0;
            if (!w_flushing) begin
                if (w_head.valid && i_mul_done) begin
                    r_res       <= i_mul_o;
                    r_res_valid <= N_REQ'(1) << w_head.id;
                end
                if (w_head.valid ^ i_mul_done) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_mul_start = r_mul_start;
    assign o_mul_x     = r_mul_x;
    assign o_mul_y     = r_mul_y;
    assign o_res       = r_res;
    assign o_res_valid = r_res_valid;
    assign o_err       = r_err;

`ifdef MODMUL_ARB_PERF_EN
    logic [N_REQ-1:0][15:0] r_gnt_cnt;
    logic [15:0]            r_busy_cnt;
    logic [15:0]            r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gnt_cnt   <= '0;
            r_busy_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                if (w_gnt[k] && (r_gnt_cnt[k] != 16'hFFFF)) begin
                    r_gnt_cnt[k] <= r_gnt_cnt[k] + 16'd1;
                end
            end
            if (r_mul_start && (r_busy_cnt != 16'hFFFF)) begin
                r_busy_cnt <= r_busy_cnt + 16'd1;
            end
            if (|(i_req & ~w_gnt) && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_gnt_cnt   = r_gnt_cnt;
    assign o_busy_cnt  = r_busy_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
